fetch_exec_core: RTL and testbench
==================================

Name: fetch_exec_core

Overview:
- Minimal single-issue fetch/execute core: program counter, instruction register, decode, 32-bit ALU and a 32x32 register file.
- Drives an external combinational instruction memory through the PC and captures the returned word into the IR.
- The IR word is decoded and the ALU result is written back to the register file.
- Used as the top datapath of the simple CPU; supports add, sub, addi and the custom subi.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per clock (byte addressing).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets, 1 runs.
- pc_value  out  32  current PC; address to the instruction memory.
- imem_data  in  32  instruction word at pc_value (combinational memory).
- instruction  out  32  current IR contents.
- reg_we  out  1  register-file write enable for the IR instruction.
- alu_result  out  32  write-back data for the IR instruction.
- dbg_addr  in  5  debug register-file read address.
- dbg_data  out  32  debug read data, combinational; 0 when dbg_addr=0.

Behaviour:
- Reset (reset=0, asynchronous, independent of clock):
  - pc_value=RESET_PC, instruction=0, all registers x1..x31=0.
  - Outputs settle with no clock edge. Release is sampled at the next rising edge.
- PC: each rising edge out of reset, pc <= pc + PC_STEP, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- IR: each rising edge out of reset, IR <= imem_data. The word at address A is in the IR one cycle after the PC equals A.
- Decode fields from the IR:
  - opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
  - imm = sign-extended [31:20].
- Instruction classes:
  - add: opcode 0110011, funct3 000, funct7 0000000 -> rs1+rs2.
  - sub: opcode 0110011, funct3 000, funct7 0100000 -> rs1-rs2.
  - addi: opcode 0010011, funct3 000 -> rs1+imm.
  - subi (custom): opcode 0010011, funct3 001 -> rs1-imm.
  - Any other encoding: reg_we=0, alu_result=0. The reset IR value 0 is therefore a NOP.
- Arithmetic: 32-bit, wraps modulo 2^32, no flags or exceptions.
- reg_we = add|sub|addi|subi. It is combinational from the IR.
- Register file:
  - Two combinational read ports (rs1, rs2) plus the debug port.
  - One write port, written on the rising edge when reg_we=1 at address rd.
- x0 rule: x0 always reads 0; writes with rd=0 are discarded.
- Timing: the instruction in the IR commits at the edge that also loads the next IR. The next instruction therefore reads the updated value, so back-to-back dependencies need no forwarding or stall.
- Reads during a write cycle return the pre-edge value.
- Reset asserted mid-program: PC, IR and registers clear immediately; any pending write is lost.
- No stall, branch or halt. Execution continues sequentially while reset=1.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> pc_value=0, instruction=0, reg_we=0, dbg_data=0 for every dbg_addr. Release -> pc_value steps 0,4,8,12 on successive edges.
- addi: memory holds 0x00500093, 0x00300113 (addi x1,x0,5; addi x2,x0,3) -> x1=5, x2=3. Each write occurs one edge after its IR load.
- add/sub back-to-back: follow with 0x00208233 (add x4,x1,x2) and 0x402082B3 (sub x5,x1,x2) -> x4=8, x5=2. add reads x2 written on the immediately preceding edge.
- subi and sign extension:
  - 0x00109313 (subi x6,x1,1) -> x6=4.
  - 0xFFF00393 (addi x7,x0,-1) -> x7=0xFFFF_FFFF.
  - A following sub of x0 minus x7 -> result 1.
- x0 and unsupported encodings:
  - 0x00700013 (addi x0,x0,7) -> x0 still 0, reg_we=1.
  - 0x00000000 or opcode 0000011 -> reg_we=0, alu_result=0, no register changes.
- Async reset mid-run: drop reset between edges after several writes -> pc_value=RESET_PC and all registers 0 immediately, before the next edge. Execution restarts from RESET_PC after release.

Source files
------------

// File: rtl/fetch_exec_core_if.sv
// Bus between the fetch/execute core and its environment: the instruction
// memory fetch path, the write-back observation signals and the debug
// register-file read port.
// There is no handshake on this bus. The instruction memory is purely
// combinational: imem_data must reflect pc_value within the same cycle.
// The core always accepts it, and there is no valid or ready qualifier.
interface fetch_exec_core_if;
    logic [31:0] pc_value;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic        reg_we;
    logic [31:0] alu_result;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    // Core side
    modport master (
        output pc_value,
        output instruction,
        output reg_we,
        output alu_result,
        output dbg_data,
        input  imem_data,
        input  dbg_addr
    );

    // Memory / observer side
    modport slave (
        input  pc_value,
        input  instruction,
        input  reg_we,
        input  alu_result,
        input  dbg_data,
        output imem_data,
        output dbg_addr
    );
endinterface

// File: rtl/fetch_exec_core.sv
// Minimal single-issue fetch/execute core.
// The PC addresses a combinational instruction memory, and the returned word is
// latched into the IR. The IR is decoded and executed in the same cycle. The
// result commits on the edge that also loads the next IR. A dependent
// instruction that immediately follows therefore reads the fresh value, so the
// core needs no forwarding and no stall.
// Supported instructions: add, sub, addi, and the custom subi. Every other
// encoding is a NOP.
module fetch_exec_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic               clock,
    input logic               reset,
    fetch_exec_core_if.master bus
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;
    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SUBI   = 3'b001;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ir_q;
    logic [31:0] ir_d;
    logic [31:0] regs_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        is_add;
    logic        is_sub;
    logic        is_addi;
    logic        is_subi;
    logic        reg_we;
    logic [31:0] alu_result;

    // Instruction field extraction from the IR
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm    = {{20{ir_q[31]}}, ir_q[31:20]};

    // Read ports: x0 is hard-wired to zero regardless of storage contents
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    // Next-state for the fetch path: sequential PC and IR capture every cycle
    always_comb begin
        pc_d = pc_q + PC_STEP;
        ir_d = bus.imem_data;
    end

    // Decode and ALU; any unrecognised encoding yields no write and a zero result
    always_comb begin
        is_add     = 1'b0;
        is_sub     = 1'b0;
        is_addi    = 1'b0;
        is_subi    = 1'b0;
        alu_result = 32'd0;
        if (opcode == OP_REG && funct3 == F3_ADD && funct7 == F7_ADD) begin
            is_add     = 1'b1;
            alu_result = rs1_val + rs2_val;
        end else if (opcode == OP_REG && funct3 == F3_ADD && funct7 == F7_SUB) begin
            is_sub     = 1'b1;
            alu_result = rs1_val - rs2_val;
        end else if (opcode == OP_IMM && funct3 == F3_ADD) begin
            is_addi    = 1'b1;
            alu_result = rs1_val + imm;
        end else if (opcode == OP_IMM && funct3 == F3_SUBI) begin
            is_subi    = 1'b1;
            alu_result = rs1_val - imm;
        end
        reg_we = is_add | is_sub | is_addi | is_subi;
    end

    // PC and IR registers; reset value of IR (all zero) decodes as a NOP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            ir_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    // Register file write port; writes to x0 are dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (reg_we && rd != 5'd0) begin
            regs_q[rd] <= alu_result;
        end
    end

    // Outputs toward memory, observer and debug port
    assign bus.pc_value    = pc_q;
    assign bus.instruction = ir_q;
    assign bus.reg_we      = reg_we;
    assign bus.alu_result  = alu_result;
    assign bus.dbg_data    = (bus.dbg_addr == 5'd0) ? 32'd0 : regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_fetch_exec_core.sv
// Testbench for fetch_exec_core: directed programs plus randomized programs
// compared against an instruction-level reference model.
module tb_fetch_exec_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Clock generation
    always #10 clk = ~clk;

    fetch_exec_core_if bus ();
    fetch_exec_core_if wbus ();

    fetch_exec_core u_dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Second instance placed near the top of the address space for PC wrap
    fetch_exec_core #(.RESET_PC(32'hFFFF_FFF0)) u_wrap (
        .clock (clk),
        .reset (rst_n),
        .bus   (wbus)
    );

    logic [31:0] mem [256];
    assign bus.imem_data  = mem[bus.pc_value[9:2]];
    assign wbus.imem_data = 32'h0000_0000;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state only
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_regs [32];

    function automatic void m_exec(input logic [31:0] ir, output logic we, output logic [31:0] res);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] simm;
        a    = m_regs[ir[19:15]];
        b    = m_regs[ir[24:20]];
        simm = {{20{ir[31]}}, ir[31:20]};
        we   = 1'b1;
        res  = 32'd0;
        if (ir[6:0] == 7'h33 && ir[14:12] == 3'd0 && ir[31:25] == 7'h00)      res = a + b;
        else if (ir[6:0] == 7'h33 && ir[14:12] == 3'd0 && ir[31:25] == 7'h20) res = a - b;
        else if (ir[6:0] == 7'h13 && ir[14:12] == 3'd0)                       res = a + simm;
        else if (ir[6:0] == 7'h13 && ir[14:12] == 3'd1)                       res = a - simm;
        else                                                                  we = 1'b0;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        m_ir = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // One rising edge: commit the IR instruction, then fetch the next word
    task automatic model_edge();
        logic        we;
        logic [31:0] res;
        m_exec(m_ir, we, res);
        if (we && m_ir[11:7] != 5'd0) m_regs[m_ir[11:7]] = res;
        m_ir = mem[m_pc[9:2]];
        m_pc = m_pc + 32'd4;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [31:0] w;
        rd  = 5'($urandom_range(0, 15));
        rs1 = 5'($urandom_range(0, 15));
        rs2 = 5'($urandom_range(0, 15));
        imm = 12'($urandom());
        w   = $urandom();
        case ($urandom_range(0, 7))
            0, 1:    gen_instr = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            2:       gen_instr = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
            3, 4:    gen_instr = {imm, rs1, 3'b000, rd, 7'h13};
            5:       gen_instr = {imm, rs1, 3'b001, rd, 7'h13};
            6:       gen_instr = {7'h01, rs2, rs1, 3'b000, rd, 7'h33};
            default: gen_instr = {w[31:7], 7'b0000011};
        endcase
    endfunction

    task automatic load_directed();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'h0050_0093; // addi x1,x0,5
        mem[1] = 32'h0030_0113; // addi x2,x0,3
        mem[2] = 32'h0020_8233; // add  x4,x1,x2
        mem[3] = 32'h4020_82B3; // sub  x5,x1,x2
        mem[4] = 32'h0010_9313; // subi x6,x1,1
        mem[5] = 32'hFFF0_0393; // addi x7,x0,-1
        mem[6] = 32'h4070_0433; // sub  x8,x0,x7
        mem[7] = 32'h0070_0013; // addi x0,x0,7
        mem[8] = 32'h0000_0000; // all-zero word
        mem[9] = 32'h0050_8183; // opcode 0000011
    endtask

    // Asserts reset at a falling edge and holds it across two rising edges
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        apply_reset();
        checks++;
        if (bus.pc_value !== 32'd0) begin
            errors++; $display("FAIL reset_pc got %h exp %h", bus.pc_value, 32'd0);
        end
        checks++;
        if (bus.instruction !== 32'd0) begin
            errors++; $display("FAIL reset_ir got %h exp %h", bus.instruction, 32'd0);
        end
        checks++;
        if (bus.reg_we !== 1'b0 || bus.alu_result !== 32'd0) begin
            errors++; $display("FAIL reset_we got %b/%h exp 0/0", bus.reg_we, bus.alu_result);
        end
        for (int a = 0; a < 32; a++) begin
            bus.dbg_addr = 5'(a);
            #1;
            checks++;
            if (bus.dbg_data !== 32'd0) begin
                errors++; $display("FAIL reset_reg x%0d got %h exp 0", a, bus.dbg_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.pc_value !== 32'((k + 1) * 4)) begin
                errors++; $display("FAIL release_pc step %0d got %h exp %h", k, bus.pc_value, 32'((k + 1) * 4));
            end
        end
    endtask

    task automatic test_directed();
        logic        we_m;
        logic [31:0] res_m;
        logic [31:0] exp_v [9];
        load_directed();
        apply_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            m_exec(m_ir, we_m, res_m);
            checks++;
            if (bus.pc_value !== m_pc) begin
                errors++; $display("FAIL dir_pc cyc %0d got %h exp %h", c, bus.pc_value, m_pc);
            end
            checks++;
            if (bus.instruction !== m_ir) begin
                errors++; $display("FAIL dir_ir cyc %0d got %h exp %h", c, bus.instruction, m_ir);
            end
            checks++;
            if (bus.reg_we !== we_m || bus.alu_result !== res_m) begin
                errors++; $display("FAIL dir_alu cyc %0d got %b/%h exp %b/%h", c, bus.reg_we, bus.alu_result, we_m, res_m);
            end
            if (m_ir == 32'h0070_0013) begin
                checks++;
                if (bus.reg_we !== 1'b1 || bus.alu_result !== 32'd7) begin
                    errors++; $display("FAIL x0_write_we got %b/%h exp 1/7", bus.reg_we, bus.alu_result);
                end
            end
            for (int a = 1; a <= 8; a++) begin
                bus.dbg_addr = 5'(a);
                #1;
                checks++;
                if (bus.dbg_data !== m_regs[a]) begin
                    errors++; $display("FAIL dir_reg cyc %0d x%0d got %h exp %h", c, a, bus.dbg_data, m_regs[a]);
                end
            end
        end
        exp_v = '{32'd0, 32'd5, 32'd3, 32'd0, 32'd8, 32'd2, 32'd4, 32'hFFFF_FFFF, 32'd1};
        for (int a = 0; a < 9; a++) begin
            bus.dbg_addr = 5'(a);
            #1;
            checks++;
            if (bus.dbg_data !== exp_v[a]) begin
                errors++; $display("FAIL dir_final x%0d got %h exp %h", a, bus.dbg_data, exp_v[a]);
            end
        end
    endtask

    task automatic test_random();
        logic        we_m;
        logic [31:0] res_m;
        logic [4:0]  ra;
        for (int i = 0; i < 256; i++) mem[i] = (i < 200) ? gen_instr() : 32'd0;
        apply_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 202; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            m_exec(m_ir, we_m, res_m);
            checks++;
            if (bus.pc_value !== m_pc || bus.instruction !== m_ir) begin
                errors++; $display("FAIL rnd_fetch cyc %0d got %h/%h exp %h/%h", c, bus.pc_value, bus.instruction, m_pc, m_ir);
            end
            checks++;
            if (bus.reg_we !== we_m || bus.alu_result !== res_m) begin
                errors++; $display("FAIL rnd_alu cyc %0d ir %h got %b/%h exp %b/%h", c, m_ir, bus.reg_we, bus.alu_result, we_m, res_m);
            end
            ra = 5'($urandom_range(0, 31));
            bus.dbg_addr = ra;
            #1;
            checks++;
            if (bus.dbg_data !== m_regs[ra]) begin
                errors++; $display("FAIL rnd_reg cyc %0d x%0d got %h exp %h", c, ra, bus.dbg_data, m_regs[ra]);
            end
        end
        // Only NOP words remain ahead, so the register file is stable now
        for (int a = 0; a < 32; a++) begin
            bus.dbg_addr = 5'(a);
            #1;
            checks++;
            if (bus.dbg_data !== m_regs[a]) begin
                errors++; $display("FAIL rnd_final x%0d got %h exp %h", a, bus.dbg_data, m_regs[a]);
            end
        end
    endtask

    task automatic test_async_reset();
        load_directed();
        apply_reset();
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        bus.dbg_addr = 5'd1;
        #1;
        checks++;
        if (bus.dbg_data !== 32'd5) begin
            errors++; $display("FAIL pre_reset_x1 got %h exp %h", bus.dbg_data, 32'd5);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.pc_value !== 32'd0 || bus.instruction !== 32'd0) begin
            errors++; $display("FAIL async_fetch got %h/%h exp 0/0", bus.pc_value, bus.instruction);
        end
        checks++;
        if (bus.reg_we !== 1'b0 || bus.dbg_data !== 32'd0) begin
            errors++; $display("FAIL async_x1 got %b/%h exp 0/0", bus.reg_we, bus.dbg_data);
        end
        bus.dbg_addr = 5'd4;
        #1;
        checks++;
        if (bus.dbg_data !== 32'd0) begin
            errors++; $display("FAIL async_x4 got %h exp 0", bus.dbg_data);
        end
        for (int a = 0; a < 32; a++) begin
            bus.dbg_addr = 5'(a);
            #1;
            checks++;
            if (bus.dbg_data !== 32'd0) begin
                errors++; $display("FAIL async_sweep x%0d got %h exp 0", a, bus.dbg_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            checks++;
            if (bus.pc_value !== m_pc || bus.instruction !== m_ir) begin
                errors++; $display("FAIL restart cyc %0d got %h/%h exp %h/%h", c, bus.pc_value, bus.instruction, m_pc, m_ir);
            end
        end
        bus.dbg_addr = 5'd4;
        #1;
        checks++;
        if (bus.dbg_data !== 32'd8) begin
            errors++; $display("FAIL restart_x4 got %h exp %h", bus.dbg_data, 32'd8);
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc;
        apply_reset();
        checks++;
        if (wbus.pc_value !== 32'hFFFF_FFF0) begin
            errors++; $display("FAIL wrap_reset got %h exp %h", wbus.pc_value, 32'hFFFF_FFF0);
        end
        rst_n = 1'b1;
        exp_pc = 32'hFFFF_FFF0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
            checks++;
            if (wbus.pc_value !== exp_pc) begin
                errors++; $display("FAIL wrap_pc step %0d got %h exp %h", k, wbus.pc_value, exp_pc);
            end
        end
    endtask

    // Test sequence and final report
    initial begin
        bus.dbg_addr  = 5'd0;
        wbus.dbg_addr = 5'd0;
        model_reset();
        test_reset();
        test_directed();
        test_random();
        test_async_reset();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
